// File: rtl/rc4_stream_gen.sv
// RC4 keystream generator: S-box init, key scheduling and byte-at-a-time
// keystream output over a valid/ready handshake, using one 256x8 S-box.
module rc4_stream_gen #(
    parameter int KEY_MAX_BYTES = 16,
    parameter int LEN_W         = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             abort,
    input  logic [8*KEY_MAX_BYTES-1:0]       key,
    input  logic [$clog2(KEY_MAX_BYTES+1)-1:0] key_len,
    input  logic [LEN_W-1:0]                 num_bytes,
    output logic [7:0]                       ks_data,
    output logic                             ks_valid,
    input  logic                             ks_ready,
    output logic                             busy,
    output logic                             done,
    output logic                             err
);

    localparam int KL_W = $clog2(KEY_MAX_BYTES + 1);
    localparam logic [KL_W-1:0] KEY_MAX_L = KL_W'(KEY_MAX_BYTES);

    typedef enum logic [2:0] {ST_IDLE, ST_INIT, ST_KSA, ST_PRGA, ST_DONE} state_t;
    typedef enum logic [1:0] {PH_0, PH_1, PH_2, PH_3} phase_t;

    state_t state;
    phase_t phase;

    logic [7:0]                 i_idx;
    logic [7:0]                 j_idx;
    logic [KL_W-1:0]            kidx;
    logic [LEN_W-1:0]           cnt;

    logic [8*KEY_MAX_BYTES-1:0] key_q;
    logic [KL_W-1:0]            key_len_q;
    logic [LEN_W-1:0]           num_q;
    logic [7:0]                 si_p0;
    logic [7:0]                 sj_p1;

    logic [7:0]                 sbox [256];

    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;

    logic [7:0] i_inc;
    logic [7:0] j_ksa;
    logic [7:0] j_prga;
    logic [7:0] t_idx;
    logic [7:0] key_byte;
    logic [7:0] out_byte;
    logic       key_len_bad;
    logic       start_ok;
    logic       idle_like;

    assign busy        = (state == ST_INIT) || (state == ST_KSA) || (state == ST_PRGA);
    assign idle_like   = (state == ST_IDLE) || (state == ST_DONE);
    assign key_len_bad = (key_len == '0) || (key_len > KEY_MAX_L);
    assign start_ok    = rst_n && idle_like && start && !key_len_bad;

    assign i_inc  = i_idx + 8'd1;
    assign j_ksa  = j_idx + si_p0 + key_byte;
    assign j_prga = j_idx + si_p0;
    assign t_idx  = si_p0 + sj_p1;

    always_comb begin
        key_byte = 8'h00;
        for (int k = 0; k < KEY_MAX_BYTES; k++) begin
            if (kidx == KL_W'(k)) key_byte = key_q[8*k +: 8];
        end
    end

    // S-box read port: each phase reads the operand it needs next
    always_comb begin
        rd_addr = 8'h00;
        if (state == ST_KSA) begin
            case (phase)
                PH_0:    rd_addr = i_idx;
                PH_1:    rd_addr = j_ksa;
                default: rd_addr = 8'h00;
            endcase
        end else if (state == ST_PRGA) begin
            case (phase)
                PH_0:    rd_addr = i_inc;
                PH_1:    rd_addr = j_prga;
                PH_2:    rd_addr = t_idx;
                default: rd_addr = 8'h00;
            endcase
        end
    end

    assign rd_data = sbox[rd_addr];

    // The swap is split: S[j] takes S[i] while old S[j] is read in the same
    // cycle, then S[i] takes old S[j]; this also gives the right result for i==j.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = 8'h00;
        wr_data = 8'h00;
        if (rst_n && !abort) begin
            case (state)
                ST_INIT: begin
                    wr_en   = 1'b1;
                    wr_addr = i_idx;
                    wr_data = i_idx;
                end
                ST_KSA, ST_PRGA: begin
                    if (phase == PH_1) begin
                        wr_en   = 1'b1;
                        wr_addr = (state == ST_KSA) ? j_ksa : j_prga;
                        wr_data = si_p0;
                    end else if (phase == PH_2) begin
                        wr_en   = 1'b1;
                        wr_addr = i_idx;
                        wr_data = sj_p1;
                    end
                end
                default: wr_en = 1'b0;
            endcase
        end
    end

    // S[i] is written in the same cycle as the output read; forward it
    assign out_byte = (t_idx == i_idx) ? sj_p1 : rd_data;

    always_ff @(posedge clk) begin
        if (wr_en) sbox[wr_addr] <= wr_data;
    end

    // Session operands and swap operands
    always_ff @(posedge clk) begin
        if (start_ok) begin
            key_q     <= key;
            key_len_q <= key_len;
            num_q     <= num_bytes;
        end
        if ((state == ST_KSA || state == ST_PRGA) && phase == PH_0) si_p0 <= rd_data;
        if ((state == ST_KSA || state == ST_PRGA) && phase == PH_1) sj_p1 <= rd_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            phase    <= PH_0;
            i_idx    <= 8'h00;
            j_idx    <= 8'h00;
            kidx     <= '0;
            cnt      <= '0;
            ks_data  <= 8'h00;
            ks_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (abort && busy) begin
                state    <= ST_IDLE;
                phase    <= PH_0;
                ks_valid <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            if (key_len_bad) begin
                                err <= 1'b1;
                            end else begin
                                state <= ST_INIT;
                                i_idx <= 8'h00;
                                j_idx <= 8'h00;
                            end
                        end
                    end
                    ST_INIT: begin
                        i_idx <= i_inc;
                        if (i_idx == 8'd255) begin
                            state <= ST_KSA;
                            phase <= PH_0;
                            j_idx <= 8'h00;
                            kidx  <= '0;
                        end
                    end
                    ST_KSA: begin
                        case (phase)
                            PH_0: phase <= PH_1;
                            PH_1: begin
                                j_idx <= j_ksa;
                                phase <= PH_2;
                            end
                            PH_2: begin
                                i_idx <= i_inc;
                                kidx  <= (kidx == key_len_q - 1'b1) ? '0 : kidx + 1'b1;
                                phase <= PH_0;
                                if (i_idx == 8'd255) begin
                                    j_idx <= 8'h00;
                                    cnt   <= '0;
                                    if (num_q == '0) begin
                                        state <= ST_DONE;
                                        done  <= 1'b1;
                                    end else begin
                                        state <= ST_PRGA;
                                    end
                                end
                            end
                            default: phase <= PH_0;
                        endcase
                    end
                    ST_PRGA: begin
                        case (phase)
                            PH_0: begin
                                i_idx <= i_inc;
                                phase <= PH_1;
                            end
                            PH_1: begin
                                j_idx <= j_prga;
                                phase <= PH_2;
                            end
                            PH_2: begin
                                ks_data  <= out_byte;
                                ks_valid <= 1'b1;
                                phase    <= PH_3;
                            end
                            default: begin
                                if (ks_ready) begin
                                    ks_valid <= 1'b0;
                                    cnt      <= cnt + 1'b1;
                                    phase    <= PH_0;
                                    if (cnt == num_q - 1'b1) begin
                                        state <= ST_DONE;
                                        done  <= 1'b1;
                                    end
                                end
                            end
                        endcase
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rc4_stream_gen.sv
// Self-checking bench for rc4_stream_gen: known-answer vectors, random keys
// against a plain RC4 model, start rejection, abort and mid-session reset.
module tb_rc4_stream_gen;

    localparam int KMB   = 16;
    localparam int LEN_W = 16;
    localparam int KL_W  = $clog2(KMB + 1);

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic                 abort;
    logic [8*KMB-1:0]     key;
    logic [KL_W-1:0]      key_len;
    logic [LEN_W-1:0]     num_bytes;
    logic [7:0]           ks_data;
    logic                 ks_valid;
    logic                 ks_ready;
    logic                 busy;
    logic                 done;
    logic                 err;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] kbytes [$];
    logic [7:0] exp_q  [$];

    rc4_stream_gen #(.KEY_MAX_BYTES(KMB), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .key(key), .key_len(key_len), .num_bytes(num_bytes),
        .ks_data(ks_data), .ks_valid(ks_valid), .ks_ready(ks_ready),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key();
        key = '0;
        for (int k = 0; k < kbytes.size(); k++) key[8*k +: 8] = kbytes[k];
    endtask

    // Textbook RC4 over the bytes in kbytes
    task automatic build_expected(input int klen, input int nb);
        int s [256];
        int i, j, t;
        for (int n = 0; n < 256; n++) s[n] = n;
        j = 0;
        for (int n = 0; n < 256; n++) begin
            j = (j + s[n] + int'(kbytes[n % klen])) % 256;
            t = s[n]; s[n] = s[j]; s[j] = t;
        end
        i = 0;
        j = 0;
        exp_q.delete();
        for (int n = 0; n < nb; n++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            exp_q.push_back(8'(s[(s[i] + s[j]) % 256]));
        end
    endtask

    task automatic run_session(input string name, input int klen, input int nb, input bit rand_ready);
        int         got;
        int         cycles;
        int         first_cyc;
        int         last_vcyc;
        int         done_cyc;
        bit         prev_stall;
        bit         valid_seen;
        logic [7:0] prev_data;
        got = 0; cycles = 0; first_cyc = -1; last_vcyc = -1; done_cyc = -1;
        prev_stall = 1'b0; valid_seen = 1'b0; prev_data = 8'h00;
        key_len   = KL_W'(klen);
        num_bytes = LEN_W'(nb);
        start     = 1'b1;
        cyc();
        start = 1'b0;
        chk({name, "_busy_after_start"}, 32'(busy), 32'd1);
        key       = ~key;
        key_len   = KL_W'($urandom);
        num_bytes = LEN_W'($urandom);
        while (done_cyc < 0 && cycles < 4000) begin
            ks_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_stall) begin
                chk({name, "_stall_valid"}, 32'(ks_valid), 32'd1);
                chk({name, "_stall_data"}, 32'(ks_data), 32'(prev_data));
            end
            if (ks_valid) begin
                valid_seen = 1'b1;
                if (first_cyc < 0) first_cyc = cycles;
                if (!rand_ready && last_vcyc >= 0)
                    chk({name, "_gap_le4"}, 32'((cycles - last_vcyc) <= 4), 32'd1);
                last_vcyc = cycles;
                if (ks_ready) begin
                    if (got < exp_q.size())
                        chk($sformatf("%s_byte%0d", name, got), 32'(ks_data), 32'(exp_q[got]));
                    else
                        chk({name, "_extra_byte"}, 32'(got + 1), 32'(nb));
                    got++;
                end
            end
            if (done) begin
                done_cyc = cycles;
                chk({name, "_valid_at_done"}, 32'(ks_valid), 32'd0);
            end
            prev_stall = ks_valid && !ks_ready;
            prev_data  = ks_data;
            cyc();
            cycles++;
        end
        ks_ready = 1'b0;
        chk({name, "_byte_count"}, 32'(got), 32'(nb));
        chk({name, "_done_seen"}, 32'(done_cyc >= 0), 32'd1);
        if (nb == 0) begin
            chk({name, "_done_cycle"}, 32'(done_cyc), 32'd1024);
            chk({name, "_no_valid"}, 32'(valid_seen), 32'd0);
        end else begin
            chk({name, "_first_valid_latency"},
                32'(first_cyc >= 1025 && first_cyc <= 1032), 32'd1);
        end
        chk({name, "_done_one_cycle"}, 32'(done), 32'd0);
        chk({name, "_idle_after_done"}, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_ks_valid"}, 32'(ks_valid), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_err"}, 32'(err), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_ks_data"}, 32'(ks_data), 32'd0);
    endtask

    task automatic reject_start(input string name, input int klen);
        key_len   = KL_W'(klen);
        num_bytes = LEN_W'(5);
        start     = 1'b1;
        cyc();
        start = 1'b0;
        chk({name, "_err_pulse"}, 32'(err), 32'd1);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        cyc();
        chk({name, "_err_cleared"}, 32'(err), 32'd0);
        repeat (4) cyc();
        chk({name, "_no_valid"}, 32'(ks_valid), 32'd0);
        chk({name, "_still_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic set_key_kat();
        kbytes = '{8'h4B, 8'h65, 8'h79};
        load_key();
        exp_q = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
    endtask

    initial begin
        int n;
        int klen;
        int nb;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; ks_ready = 1'b0;
        key = '0; key_len = '0; num_bytes = '0;
        repeat (2) cyc();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        cyc();

        set_key_kat();
        run_session("key", 3, 10, 1'b0);

        kbytes = '{8'h57, 8'h69, 8'h6B, 8'h69};
        load_key();
        exp_q = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41, 8'hB7};
        run_session("wiki", 4, 6, 1'b1);

        kbytes = '{8'h53, 8'h65, 8'h63, 8'h72, 8'h65, 8'h74};
        load_key();
        exp_q = '{8'h04, 8'hD4, 8'h6B, 8'h05, 8'h3C, 8'hA8, 8'h7B, 8'h59};
        run_session("secret1", 6, 8, 1'b0);
        load_key();
        run_session("secret2", 6, 8, 1'b1);

        reject_start("len0", 0);
        reject_start("len_over", KMB + 1);

        set_key_kat();
        exp_q.delete();
        run_session("nb0", 3, 0, 1'b0);

        // Abort while scheduling the key
        set_key_kat();
        key_len = KL_W'(3); num_bytes = LEN_W'(10); start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (500) cyc();
        chk("abort_ksa_busy_before", 32'(busy), 32'd1);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_ksa_busy", 32'(busy), 32'd0);
        chk("abort_ksa_valid", 32'(ks_valid), 32'd0);
        chk("abort_ksa_done", 32'(done), 32'd0);
        repeat (600) begin
            cyc();
            if (ks_valid || done) chk("abort_ksa_quiet", 32'({ks_valid, done}), 32'd0);
        end

        // Abort during a stalled output, with a same-cycle handshake
        key_len = KL_W'(3); num_bytes = LEN_W'(10); ks_ready = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        n = 0;
        while (!ks_valid && n < 1100) begin cyc(); n++; end
        chk("abort_prga_valid_reached", 32'(ks_valid), 32'd1);
        repeat (2) cyc();
        abort = 1'b1;
        ks_ready = 1'b1;
        cyc();
        abort = 1'b0;
        ks_ready = 1'b0;
        chk("abort_prga_valid", 32'(ks_valid), 32'd0);
        chk("abort_prga_busy", 32'(busy), 32'd0);
        chk("abort_prga_done", 32'(done), 32'd0);
        cyc();
        chk("abort_prga_done_next", 32'(done), 32'd0);

        // Reset in the middle of the keystream, then a clean rerun
        set_key_kat();
        key_len = KL_W'(3); num_bytes = LEN_W'(10); ks_ready = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        n = 0;
        klen = 0;
        while (klen < 3 && n < 1200) begin
            cyc();
            n++;
            if (ks_valid) klen++;
        end
        chk("midreset_reached_prga", 32'(klen), 32'd3);
        ks_ready = 1'b0;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        check_reset_outputs("midreset");
        set_key_kat();
        run_session("key_after_reset", 3, 10, 1'b0);

        // Random keys against the model
        for (int r = 0; r < 4; r++) begin
            klen = $urandom_range(1, KMB);
            nb   = $urandom_range(1, 20);
            kbytes.delete();
            for (int k = 0; k < klen; k++) kbytes.push_back(8'($urandom));
            load_key();
            build_expected(klen, nb);
            run_session($sformatf("rand%0d", r), klen, nb, r[0]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
